// File: rtl/ksadd_operand_seq.sv
// Operand sequencer and result register wrapped around a 16-bit Kogge-Stone adder.
// Operand beats enter stage A, pass through ksadd16b, and land in result stage B.
// The carry is chained across consecutive beats so wide adds can be issued LSW first.
// Optional feature macro: KSADD_OVF_EN adds out_ovf, the signed overflow of the full chained word.

module ksadd16b (
    input  logic k0, k1, k2, k3, k4, k5, k6, k7, k8, k9, k10, k11, k12, k13, k14, k15,
    input  logic t0, t1, t2, t3, t4, t5, t6, t7, t8, t9, t10, t11, t12, t13, t14, t15,
    input  logic cin,
    output logic s0, s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, s12, s13, s14, s15,
    output logic s16
);
    logic [15:0] k, t, p0, g0, p1, g1, p2, g2, p3, g3, g4, c;

    assign k = {k15, k14, k13, k12, k11, k10, k9, k8, k7, k6, k5, k4, k3, k2, k1, k0};
    assign t = {t15, t14, t13, t12, t11, t10, t9, t8, t7, t6, t5, t4, t3, t2, t1, t0};

    // Bit 0 generate absorbs cin, so g4[i] is the carry out of bit i.
    assign p0 = k ^ t;
    assign g0 = (k & t) | {15'b0, p0[0] & cin};
    assign g1 = g0 | (p0 & (g0 << 1));
    assign p1 = p0 & ((p0 << 1) | 16'h0001);
    assign g2 = g1 | (p1 & (g1 << 2));
    assign p2 = p1 & ((p1 << 2) | 16'h0003);
    assign g3 = g2 | (p2 & (g2 << 4));
    assign p3 = p2 & ((p2 << 4) | 16'h000F);
    assign g4 = g3 | (p3 & (g3 << 8));
    assign c  = {g4[14:0], cin};

    assign {s15, s14, s13, s12, s11, s10, s9, s8, s7, s6, s5, s4, s3, s2, s1, s0} = p0 ^ c;
    assign s16 = g4[15];
endmodule

module ksadd_operand_seq #(
    parameter int MAX_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_k,
    input  logic [15:0] in_t,
    input  logic        in_cin,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_cout,
    output logic        out_last,
    output logic [3:0]  out_idx,
    output logic        err_trunc
`ifdef KSADD_OVF_EN
    ,
    output logic        out_ovf
`endif
);
    typedef enum logic {FIRST = 1'b0, CHAIN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        a_full_q, a_cin_q, a_last_q;
    logic [15:0] a_k_q, a_t_q;
    logic        carry_q;
    logic [3:0]  cnt_q;
    logic        b_vld_q, b_cout_q, b_last_q, err_q;
    logic [15:0] b_sum_q;
    logic [3:0]  b_idx_q;
    logic        a_move, accept;
    logic        add_cin, beat_last, forced;
    logic [3:0]  beat_idx;
    logic [15:0] sum_w;
    logic        cout_w;

    assign a_move   = a_full_q & (~b_vld_q | out_ready);
    assign in_ready = rst_n & (~a_full_q | a_move);
    assign accept   = in_valid & in_ready;

    // Stage A operand register: load on accept, empty when its beat moves on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_full_q <= 1'b0;
            a_k_q    <= '0;
            a_t_q    <= '0;
            a_cin_q  <= 1'b0;
            a_last_q <= 1'b0;
        end else if (accept) begin
            a_full_q <= 1'b1;
            a_k_q    <= in_k;
            a_t_q    <= in_t;
            a_cin_q  <= in_cin;
            a_last_q <= in_last;
        end else if (a_move) begin
            a_full_q <= 1'b0;
        end
    end

    // Carry FSM state register plus the carry and word counter it owns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FIRST;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (a_move) begin
                carry_q <= cout_w;
                cnt_q   <= beat_idx + 4'd1;
            end
        end
    end

    // Next state: a closing beat (explicit or forced) returns to FIRST.
    always_comb begin
        state_d = state_q;
        if (a_move) state_d = beat_last ? FIRST : CHAIN;
    end

    // FSM outputs: adder carry-in, word index and chain-close decision for the beat in A.
    always_comb begin
        add_cin  = a_cin_q;
        beat_idx = 4'd0;
        if (state_q == CHAIN) begin
            add_cin  = carry_q;
            beat_idx = cnt_q;
        end
        forced    = (beat_idx == 4'(MAX_WORDS - 1)) & ~a_last_q;
        beat_last = a_last_q | forced;
    end

    ksadd16b u_add (
        .k0(a_k_q[0]),   .k1(a_k_q[1]),   .k2(a_k_q[2]),   .k3(a_k_q[3]),
        .k4(a_k_q[4]),   .k5(a_k_q[5]),   .k6(a_k_q[6]),   .k7(a_k_q[7]),
        .k8(a_k_q[8]),   .k9(a_k_q[9]),   .k10(a_k_q[10]), .k11(a_k_q[11]),
        .k12(a_k_q[12]), .k13(a_k_q[13]), .k14(a_k_q[14]), .k15(a_k_q[15]),
        .t0(a_t_q[0]),   .t1(a_t_q[1]),   .t2(a_t_q[2]),   .t3(a_t_q[3]),
        .t4(a_t_q[4]),   .t5(a_t_q[5]),   .t6(a_t_q[6]),   .t7(a_t_q[7]),
        .t8(a_t_q[8]),   .t9(a_t_q[9]),   .t10(a_t_q[10]), .t11(a_t_q[11]),
        .t12(a_t_q[12]), .t13(a_t_q[13]), .t14(a_t_q[14]), .t15(a_t_q[15]),
        .cin(add_cin),
        .s0(sum_w[0]),   .s1(sum_w[1]),   .s2(sum_w[2]),   .s3(sum_w[3]),
        .s4(sum_w[4]),   .s5(sum_w[5]),   .s6(sum_w[6]),   .s7(sum_w[7]),
        .s8(sum_w[8]),   .s9(sum_w[9]),   .s10(sum_w[10]), .s11(sum_w[11]),
        .s12(sum_w[12]), .s13(sum_w[13]), .s14(sum_w[14]), .s15(sum_w[15]),
        .s16(cout_w)
    );

    // Stage B result register: load on a move, hold under back-pressure, drain on out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_vld_q  <= 1'b0;
            b_sum_q  <= '0;
            b_cout_q <= 1'b0;
            b_last_q <= 1'b0;
            b_idx_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (a_move) begin
                b_vld_q  <= 1'b1;
                b_sum_q  <= sum_w;
                b_cout_q <= cout_w;
                b_last_q <= beat_last;
                b_idx_q  <= beat_idx;
            end else if (out_ready) begin
                b_vld_q <= 1'b0;
            end
            err_q <= err_q | (a_move & forced);
        end
    end

`ifdef KSADD_OVF_EN
    logic b_ovf_q;

    // Signed overflow of the whole chained word, reported only on its closing beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_ovf_q <= 1'b0;
        end else if (a_move) begin
            b_ovf_q <= beat_last & (a_k_q[15] == a_t_q[15]) & (sum_w[15] != a_k_q[15]);
        end
    end

    assign out_ovf = b_ovf_q;
`endif

    assign out_valid = b_vld_q;
    assign out_sum   = b_sum_q;
    assign out_cout  = b_cout_q;
    assign out_last  = b_last_q;
    assign out_idx   = b_idx_q;
    assign err_trunc = err_q;
endmodule

// File: tb/tb_ksadd_operand_seq.sv
// Directed bench for ksadd_operand_seq (MAX_WORDS = 4). Inputs change 1 ns after a
// rising edge; outputs are sampled at the same point, reflecting that edge.

module tb_ksadd_operand_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_k = '0;
    logic [15:0] in_t = '0;
    logic        in_cin = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_last;
    logic [3:0]  out_idx;
    logic        err_trunc;
`ifdef KSADD_OVF_EN
    logic        out_ovf;
`endif

    int total = 0;
    int bad = 0;

    ksadd_operand_seq #(.MAX_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_k(in_k), .in_t(in_t), .in_cin(in_cin), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_last(out_last),
        .out_idx(out_idx), .err_trunc(err_trunc)
`ifdef KSADD_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] k, input logic [15:0] t, input logic c, input logic l);
        in_valid = 1'b1;
        in_k = k;
        in_t = t;
        in_cin = c;
        in_last = l;
    endtask

    // One isolated beat with a free output; returns what stage B showed one edge after accept.
    task automatic run_single(input logic [15:0] k, input logic [15:0] t, input logic c,
                              input logic l, output logic [15:0] s, output logic co,
                              output logic lo, output logic [3:0] ix, output logic v);
        out_ready = 1'b1;
        drive(k, t, c, l);
        tick();
        in_valid = 1'b0;
        tick();
        s = out_sum; co = out_cout; lo = out_last; ix = out_idx; v = out_valid;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (out_sum !== 16'h0000 || out_idx !== 4'd0 || out_last !== 1'b0 || out_cout !== 1'b0)
            begin bad++; $display("FAIL rst_outputs sum=%h idx=%0d last=%b cout=%b want 0", out_sum, out_idx, out_last, out_cout); end
        total++; if (err_trunc !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_trunc); end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(16'h1234, 16'h4321, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1 || out_sum !== 16'h5555 || out_cout !== 1'b0 || out_last !== 1'b1 || out_idx !== 4'd0)
            begin bad++; $display("FAIL single_beat v=%b sum=%h cout=%b last=%b idx=%0d want 1 5555 0 1 0",
                                  out_valid, out_sum, out_cout, out_last, out_idx); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_carry();
        logic [15:0] s; logic co, lo, v; logic [3:0] ix;
        run_single(16'hFFFF, 16'h0001, 1'b0, 1'b1, s, co, lo, ix, v);
        total++; if (v !== 1'b1 || s !== 16'h0000 || co !== 1'b1)
            begin bad++; $display("FAIL carry_cin0 v=%b sum=%h cout=%b want 1 0000 1", v, s, co); end
        run_single(16'hFFFF, 16'h0001, 1'b1, 1'b1, s, co, lo, ix, v);
        total++; if (v !== 1'b1 || s !== 16'h0001 || co !== 1'b1)
            begin bad++; $display("FAIL carry_cin1 v=%b sum=%h cout=%b want 1 0001 1", v, s, co); end
        run_single(16'hA5A5, 16'h5A5A, 1'b1, 1'b1, s, co, lo, ix, v);
        total++; if (s !== 16'h0000 || co !== 1'b1)
            begin bad++; $display("FAIL carry_ripple sum=%h cout=%b want 0000 1", s, co); end
    endtask

    task automatic test_chain32();
        out_ready = 1'b1;
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(16'h0000, 16'h0000, 1'b0, 1'b1);
        tick();
        total++; if (out_valid !== 1'b1 || out_sum !== 16'h0000 || out_cout !== 1'b1 || out_idx !== 4'd0 || out_last !== 1'b0)
            begin bad++; $display("FAIL chain_beat0 v=%b sum=%h cout=%b idx=%0d last=%b want 1 0000 1 0 0",
                                  out_valid, out_sum, out_cout, out_idx, out_last); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1 || out_sum !== 16'h0001 || out_cout !== 1'b0 || out_idx !== 4'd1 || out_last !== 1'b1)
            begin bad++; $display("FAIL chain_beat1 v=%b sum=%h cout=%b idx=%0d last=%b want 1 0001 0 1 1",
                                  out_valid, out_sum, out_cout, out_idx, out_last); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(16'h0001, 16'h0002, 1'b0, 1'b1);
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after1 got=%b want=1", in_ready); end
        drive(16'h0010, 16'h0020, 1'b0, 1'b1);
        tick();
        drive(16'h0100, 16'h0200, 1'b0, 1'b1);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_after2 got=%b want=0", in_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || out_sum !== 16'h0003 || in_ready !== 1'b0)
            begin bad++; $display("FAIL bp_hold v=%b sum=%h in_ready=%b want 1 0003 0", out_valid, out_sum, in_ready); end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_sum !== 16'h0030)
            begin bad++; $display("FAIL bp_beat1 v=%b sum=%h want 1 0030", out_valid, out_sum); end
        tick();
        total++; if (out_valid !== 1'b1 || out_sum !== 16'h0300)
            begin bad++; $display("FAIL bp_beat2 v=%b sum=%h want 1 0300", out_valid, out_sum); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_trunc();
        logic [15:0] k_v [5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000};
        logic [15:0] t_v [5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
        logic        c_v [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] s_e [5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0001};
        logic        co_e[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        l_e [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  i_e [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        logic        e_e [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) drive(k_v[i], t_v[i], c_v[i], 1'b0);
            else in_valid = 1'b0;
            tick();
            if (i > 0) begin
                total++;
                if (out_valid !== 1'b1 || out_sum !== s_e[i-1] || out_cout !== co_e[i-1] ||
                    out_last !== l_e[i-1] || out_idx !== i_e[i-1] || err_trunc !== e_e[i-1])
                    begin bad++; $display("FAIL trunc_beat%0d v=%b sum=%h cout=%b last=%b idx=%0d err=%b want 1 %h %b %b %0d %b",
                        i-1, out_valid, out_sum, out_cout, out_last, out_idx, err_trunc,
                        s_e[i-1], co_e[i-1], l_e[i-1], i_e[i-1], e_e[i-1]); end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [15:0] s; logic co, lo, v; logic [3:0] ix;
        out_ready = 1'b1;
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0 || out_sum !== 16'h0000 || out_cout !== 1'b0 || err_trunc !== 1'b0)
            begin bad++; $display("FAIL mid_rst_clear v=%b sum=%h cout=%b err=%b want 0 0000 0 0",
                                  out_valid, out_sum, out_cout, err_trunc); end
        rst_n = 1'b1;
        run_single(16'h0001, 16'h0001, 1'b0, 1'b1, s, co, lo, ix, v);
        total++; if (v !== 1'b1 || s !== 16'h0002 || ix !== 4'd0 || co !== 1'b0 || lo !== 1'b1)
            begin bad++; $display("FAIL mid_rst_beat v=%b sum=%h idx=%0d cout=%b last=%b want 1 0002 0 0 1", v, s, ix, co, lo); end
    endtask

`ifdef KSADD_OVF_EN
    task automatic test_ovf();
        out_ready = 1'b1;
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (out_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", out_ovf); end
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL ovf_notlast got=%b want=0", out_ovf); end
        drive(16'h0000, 16'h0000, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", out_ovf); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_chain32();
        test_backpressure();
        test_trunc();
        test_reset_mid();
`ifdef KSADD_OVF_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
